// File: rtl/processador_multiciclo_if.sv
// Bus between the multi-cycle execution unit and the board/test side:
// instruction word, keys, inspect addresses, and the observation outputs.
interface processador_multiciclo_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       instr;
    logic              exec_n;
    logic              insp_n;
    logic [3:0]        insp_a;
    logic [3:0]        insp_b;
    logic [DATA_W-1:0] dbg_a;
    logic [DATA_W-1:0] dbg_b;
    logic [DATA_W-1:0] result;
    logic              busy;
    logic              done;
    logic              illegal;
    logic              flag_z;
    logic              flag_c;

    modport master (
        output instr, exec_n, insp_n, insp_a, insp_b,
        input  dbg_a, dbg_b, result, busy, done, illegal, flag_z, flag_c
    );

    modport slave (
        input  instr, exec_n, insp_n, insp_a, insp_b,
        output dbg_a, dbg_b, result, busy, done, illegal, flag_z, flag_c
    );
endinterface

// File: rtl/processador_multiciclo.sv
// Multi-cycle execution unit: synchronised execute/inspect keys, register
// file with hardwired r0, ALU with Z/C flags, and an
// IDLE/DECODE/READ/EXEC/WRITE state machine.
module processador_multiciclo #(
    parameter int DATA_W     = 16,
    parameter int NREG       = 16,
    parameter int IMM_SIGNED = 0
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    processador_multiciclo_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic r_exec_s1, r_exec_s2, r_exec_d;
    logic r_insp_s1, r_insp_s2;
    logic w_start;

    logic [3:0]        r_op;
    logic [3:0]        r_rd;
    logic [3:0]        r_rb;
    logic [7:0]        r_imm8;
    logic              r_illegal;
    logic [DATA_W-1:0] r_dbg_a;
    logic [DATA_W-1:0] r_dbg_b;
    logic [DATA_W-1:0] r_result;
    logic              r_flag_z;
    logic              r_flag_c;
    logic [DATA_W-1:0] r_regs [NREG];

    logic [DATA_W-1:0] w_alu;
    logic [DATA_W:0]   w_wide;
    logic              w_carry;
    logic              w_upd_c;
    logic [DATA_W-1:0] w_imm4;
    logic [DATA_W-1:0] w_imm8;

    // 4-bit immediate extension (sign or zero depending on IMM_SIGNED)
    function automatic logic [DATA_W-1:0] ext4(input logic [3:0] v);
        if (IMM_SIGNED != 0) return DATA_W'($signed(v));
        else                 return DATA_W'(v);
    endfunction

    // 8-bit immediate extension used by LI
    function automatic logic [DATA_W-1:0] ext8(input logic [7:0] v);
        if (IMM_SIGNED != 0) return DATA_W'($signed(v));
        else                 return DATA_W'(v);
    endfunction

    // r0 and unimplemented addresses read as zero
    function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 1; i < NREG; i++) begin
            if (a == 4'(i)) v = r_regs[i];
        end
        return v;
    endfunction

    // two-flop synchronisers for both keys plus the delayed copy for edge detect
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_exec_s1 <= 1'b1;
            r_exec_s2 <= 1'b1;
            r_exec_d  <= 1'b1;
            r_insp_s1 <= 1'b1;
            r_insp_s2 <= 1'b1;
        end else begin
            r_exec_s1 <= bus.exec_n;
            r_exec_s2 <= r_exec_s1;
            r_exec_d  <= r_exec_s2;
            r_insp_s1 <= bus.insp_n;
            r_insp_s2 <= r_insp_s1;
        end
    end

    assign w_start = r_exec_d & ~r_exec_s2;

    // state register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // next-state logic; start is only honoured in IDLE so strikes while busy vanish
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_DECODE;
            S_DECODE: w_next = (bus.instr[15:14] == 2'b11) ? S_WRITE : S_READ;
            S_READ:   w_next = S_EXEC;
            S_EXEC:   w_next = S_WRITE;
            S_WRITE:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ALU: operands come from the registered dbg_a/dbg_b captured in READ
    always_comb begin
        w_alu   = r_result;
        w_wide  = '0;
        w_carry = 1'b0;
        w_upd_c = 1'b0;
        w_imm4  = ext4(r_imm8[7:4]);
        w_imm8  = ext8(r_imm8);
        case (r_op)
            4'd0: begin
                w_wide  = {1'b0, r_dbg_a} + {1'b0, r_dbg_b};
                w_alu   = w_wide[DATA_W-1:0];
                w_carry = w_wide[DATA_W];
                w_upd_c = 1'b1;
            end
            4'd1: begin
                w_alu   = r_dbg_a - r_dbg_b;
                w_carry = (r_dbg_a < r_dbg_b);
                w_upd_c = 1'b1;
            end
            4'd2: w_alu = r_dbg_a & r_dbg_b;
            4'd3: w_alu = r_dbg_a | r_dbg_b;
            4'd4: w_alu = r_dbg_a ^ r_dbg_b;
            4'd5: w_alu = (r_dbg_a < r_dbg_b) ? DATA_W'(1) : '0;
            4'd6: begin
                w_wide  = {1'b0, r_dbg_b} + {1'b0, w_imm4};
                w_alu   = w_wide[DATA_W-1:0];
                w_carry = w_wide[DATA_W];
                w_upd_c = 1'b1;
            end
            4'd7: begin
                w_alu   = r_dbg_b - w_imm4;
                w_carry = (r_dbg_b < w_imm4);
                w_upd_c = 1'b1;
            end
            4'd8:  w_alu = r_dbg_b & w_imm4;
            4'd9:  w_alu = r_dbg_b | w_imm4;
            4'd10: w_alu = (32'(r_imm8[7:4]) >= DATA_W) ? '0 : (r_dbg_b << r_imm8[7:4]);
            4'd11: w_alu = w_imm8;
            default: w_alu = r_result;
        endcase
    end

    // datapath registers: decode latch, operand capture/inspect, result and flags
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_op      <= '0;
            r_rd      <= '0;
            r_rb      <= '0;
            r_imm8    <= '0;
            r_illegal <= 1'b0;
            r_dbg_a   <= '0;
            r_dbg_b   <= '0;
            r_result  <= '0;
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_insp_s2) begin
                        r_dbg_a <= rd_reg(bus.insp_a);
                        r_dbg_b <= rd_reg(bus.insp_b);
                    end
                end
                S_DECODE: begin
                    r_op      <= bus.instr[15:12];
                    r_rd      <= bus.instr[11:8];
                    r_imm8    <= bus.instr[7:0];
                    r_rb      <= bus.instr[3:0];
                    r_illegal <= (bus.instr[15:14] == 2'b11);
                end
                S_READ: begin
                    r_dbg_a <= rd_reg(r_imm8[7:4]);
                    r_dbg_b <= rd_reg(r_rb);
                end
                S_EXEC: begin
                    r_result <= w_alu;
                    r_flag_z <= (w_alu == '0);
                    if (w_upd_c) r_flag_c <= w_carry;
                end
                default: ;
            endcase
        end
    end

    // register file write-back; r0 and addresses >= NREG are never written
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (r_state == S_WRITE && !r_illegal) begin
            for (int i = 1; i < NREG; i++) begin
                if (r_rd == 4'(i)) r_regs[i] <= r_result;
            end
        end
    end

    assign bus.dbg_a   = r_dbg_a;
    assign bus.dbg_b   = r_dbg_b;
    assign bus.result  = r_result;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_WRITE);
    assign bus.illegal = r_illegal;
    assign bus.flag_z  = r_flag_z;
    assign bus.flag_c  = r_flag_c;
endmodule

// File: tb/tb_processador_multiciclo.sv
// Directed bench for processador_multiciclo: a 16-bit/16-register/zero-extend
// instance and an 8-bit/4-register/sign-extend instance share one stimulus.
module tb_processador_multiciclo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        exec_n;
    logic        insp_n;
    logic [3:0]  insp_a;
    logic [3:0]  insp_b;

    int n_tot = 0;
    int n_bad = 0;

    processador_multiciclo_if #(.DATA_W(16)) if_a ();
    processador_multiciclo_if #(.DATA_W(8))  if_b ();

    assign if_a.instr  = instr;
    assign if_a.exec_n = exec_n;
    assign if_a.insp_n = insp_n;
    assign if_a.insp_a = insp_a;
    assign if_a.insp_b = insp_b;
    assign if_b.instr  = instr;
    assign if_b.exec_n = exec_n;
    assign if_b.insp_n = insp_n;
    assign if_b.insp_a = insp_a;
    assign if_b.insp_b = insp_b;

    processador_multiciclo #(.DATA_W(16), .NREG(16), .IMM_SIGNED(0)) dut_a (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (if_a)
    );

    processador_multiciclo #(.DATA_W(8), .NREG(4), .IMM_SIGNED(1)) dut_b (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (if_b)
    );

    always #5 clk = ~clk;

    logic [31:0] w_res  [2];
    logic [31:0] w_dbga [2];
    logic [31:0] w_dbgb [2];
    logic [1:0]  w_busy, w_done, w_ill, w_z, w_c;

    assign w_res[0]  = 32'(if_a.result);
    assign w_res[1]  = 32'(if_b.result);
    assign w_dbga[0] = 32'(if_a.dbg_a);
    assign w_dbga[1] = 32'(if_b.dbg_a);
    assign w_dbgb[0] = 32'(if_a.dbg_b);
    assign w_dbgb[1] = 32'(if_b.dbg_b);
    assign w_busy    = {if_b.busy,    if_a.busy};
    assign w_done    = {if_b.done,    if_a.done};
    assign w_ill     = {if_b.illegal, if_a.illegal};
    assign w_z       = {if_b.flag_z,  if_a.flag_z};
    assign w_c       = {if_b.flag_c,  if_a.flag_c};

    typedef struct {
        logic [15:0] iw;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        ill;
    } vec_t;

    vec_t tab_a [21];
    vec_t tab_b [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Strike exec with the given word, wait (bounded) for done, then release.
    task automatic run(input logic [15:0] iw, input int s);
        int t;
        @(negedge clk);
        instr  = iw;
        exec_n = 1'b0;
        t = 0;
        while (!w_done[s] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!w_done[s]) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        exec_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic apply(input vec_t v, input int s, input int idx);
        run(v.iw, s);
        chk($sformatf("res[%0d.%0d]", s, idx), w_res[s], v.res);
        chk($sformatf("z[%0d.%0d]",   s, idx), 32'(w_z[s]),   32'(v.z));
        chk($sformatf("c[%0d.%0d]",   s, idx), 32'(w_c[s]),   32'(v.c));
        chk($sformatf("ill[%0d.%0d]", s, idx), 32'(w_ill[s]), 32'(v.ill));
    endtask

    task automatic inspect(input logic [3:0] a, input logic [3:0] b, input int s,
                           input logic [31:0] ea, input logic [31:0] eb, input string name);
        @(negedge clk);
        insp_a = a;
        insp_b = b;
        insp_n = 1'b0;
        repeat (4) @(negedge clk);
        chk({name, "_a"}, w_dbga[s], ea);
        chk({name, "_b"}, w_dbgb[s], eb);
        insp_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] busy_exp;
        logic [8:0] done_exp;
        logic [5:0] ibusy_exp;
        logic [5:0] idone_exp;

        tab_a[0]  = '{16'hB105, 32'h0005, 1'b0, 1'b0, 1'b0};
        tab_a[1]  = '{16'hB203, 32'h0003, 1'b0, 1'b0, 1'b0};
        tab_a[2]  = '{16'h0312, 32'h0008, 1'b0, 1'b0, 1'b0};
        tab_a[3]  = '{16'h1501, 32'hFFFB, 1'b0, 1'b1, 1'b0};
        tab_a[4]  = '{16'hB1FF, 32'h00FF, 1'b0, 1'b1, 1'b0};
        tab_a[5]  = '{16'hB2FF, 32'h00FF, 1'b0, 1'b1, 1'b0};
        tab_a[6]  = '{16'hA282, 32'hFF00, 1'b0, 1'b1, 1'b0};
        tab_a[7]  = '{16'h3221, 32'hFFFF, 1'b0, 1'b1, 1'b0};
        tab_a[8]  = '{16'h7712, 32'hFFFE, 1'b0, 1'b0, 1'b0};
        tab_a[9]  = '{16'hB601, 32'h0001, 1'b0, 1'b0, 1'b0};
        tab_a[10] = '{16'h0426, 32'h0000, 1'b1, 1'b1, 1'b0};
        tab_a[11] = '{16'h2821, 32'h00FF, 1'b0, 1'b1, 1'b0};
        tab_a[12] = '{16'h4911, 32'h0000, 1'b1, 1'b1, 1'b0};
        tab_a[13] = '{16'h5A12, 32'h0001, 1'b0, 1'b1, 1'b0};
        tab_a[14] = '{16'h5B21, 32'h0000, 1'b1, 1'b1, 1'b0};
        tab_a[15] = '{16'h6C31, 32'h0102, 1'b0, 1'b0, 1'b0};
        tab_a[16] = '{16'h8DF2, 32'h000F, 1'b0, 1'b0, 1'b0};
        tab_a[17] = '{16'hAEF6, 32'h8000, 1'b0, 1'b0, 1'b0};
        tab_a[18] = '{16'h7F26, 32'hFFFF, 1'b0, 1'b1, 1'b0};
        tab_a[19] = '{16'hB007, 32'h0007, 1'b0, 1'b1, 1'b0};
        tab_a[20] = '{16'hC123, 32'h0007, 1'b0, 1'b1, 1'b1};

        tab_b[0]  = '{16'h61F0, 32'h00FF, 1'b0, 1'b0, 1'b0};
        tab_b[1]  = '{16'hB512, 32'h0012, 1'b0, 1'b0, 1'b0};
        tab_b[2]  = '{16'hB380, 32'h0080, 1'b0, 1'b0, 1'b0};
        tab_b[3]  = '{16'h0213, 32'h007F, 1'b0, 1'b1, 1'b0};
        tab_b[4]  = '{16'h72F1, 32'h0000, 1'b1, 1'b0, 1'b0};

        rst_n  = 1'b0;
        instr  = 16'h0000;
        exec_n = 1'b1;
        insp_n = 1'b1;
        insp_a = 4'd0;
        insp_b = 4'd0;
        #1;
        chk("rst_result",  w_res[0],         32'd0);
        chk("rst_dbg_a",   w_dbga[0],        32'd0);
        chk("rst_dbg_b",   w_dbgb[0],        32'd0);
        chk("rst_busy",    32'(w_busy[0]),   32'd0);
        chk("rst_done",    32'(w_done[0]),   32'd0);
        chk("rst_illegal", 32'(w_ill[0]),    32'd0);
        chk("rst_flags",   32'({w_z[0], w_c[0]}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 21; i++) apply(tab_a[i], 0, i);
        // legal op after an illegal one clears illegal
        apply('{16'h0000, 32'h0000, 1'b1, 1'b0, 1'b0}, 0, 21);

        inspect(4'd3,  4'd0,  0, 32'h0008, 32'h0000, "insp_r3_r0");
        inspect(4'd7,  4'd15, 0, 32'hFFFE, 32'hFFFF, "insp_r7_r15");
        inspect(4'd0,  4'd14, 0, 32'h0000, 32'h8000, "insp_r0_r14");
        inspect(4'd4,  4'd12, 0, 32'h0000, 32'h0102, "insp_r4_r12");

        // exact busy/done timing with extra exec strikes while busy
        busy_exp = 9'h03C;
        done_exp = 9'h020;
        @(negedge clk);
        instr  = 16'hB62A;
        exec_n = 1'b0;
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            chk($sformatf("tim_busy[%0d]", n), 32'(w_busy[0]), 32'(busy_exp[n]));
            chk($sformatf("tim_done[%0d]", n), 32'(w_done[0]), 32'(done_exp[n]));
            if (n == 2) exec_n = 1'b1;
            if (n == 3) exec_n = 1'b0;
        end
        chk("tim_result", w_res[0], 32'h002A);
        exec_n = 1'b1;
        repeat (3) @(negedge clk);
        inspect(4'd6, 4'd9, 0, 32'h002A, 32'h0000, "insp_r6_r9");

        // illegal opcode: short path, result/flags held
        ibusy_exp = 6'h0C;
        idone_exp = 6'h08;
        @(negedge clk);
        instr  = 16'hF123;
        exec_n = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk($sformatf("ill_busy[%0d]", n), 32'(w_busy[0]), 32'(ibusy_exp[n]));
            chk($sformatf("ill_done[%0d]", n), 32'(w_done[0]), 32'(idone_exp[n]));
        end
        chk("ill_flag",   32'(w_ill[0]), 32'd1);
        chk("ill_result", w_res[0],      32'h002A);
        chk("ill_z",      32'(w_z[0]),   32'd0);
        exec_n = 1'b1;
        repeat (3) @(negedge clk);

        // reset in the middle of an instruction
        @(negedge clk);
        instr  = 16'hB633;
        exec_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_result",  w_res[0],       32'd0);
        chk("mid_rst_dbg_a",   w_dbga[0],      32'd0);
        chk("mid_rst_busy",    32'(w_busy[0]), 32'd0);
        chk("mid_rst_illegal", 32'(w_ill[0]),  32'd0);
        exec_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        inspect(4'd6, 4'd3, 0, 32'h0000, 32'h0000, "insp_after_rst");

        // narrow, sign-extending instance
        for (int i = 0; i < 5; i++) apply(tab_b[i], 1, i);
        inspect(4'd5, 4'd1, 1, 32'h0000, 32'h00FF, "b_insp_r5_r1");
        inspect(4'd3, 4'd2, 1, 32'h0080, 32'h0000, "b_insp_r3_r2");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/processador_multiciclo.md
# processador_multiciclo

Parametrised multi-cycle execution unit for the board-level teaching processor: takes a 16-bit instruction word from the switches and a push-button strike, and runs it through a decode/read/execute/write-back state machine. The block contains its own register file and ALU, exposes operand and result buses for the 7-segment converters, and replaces the single-cycle switch decoder. New over the previous generation:
- configurable data width and register count;
- edge-detected, synchronised execute key;
- explicit busy/done handshake;
- illegal-opcode reporting;
- hardwired r0;
- Z/C flags.

## Interface
- DATA_W, 16, datapath and register width (4..32)
- NREG, 16, implemented registers (2..16); addresses >= NREG read 0, writes dropped
- IMM_SIGNED, 0, 1 = sign-extend immediates, 0 = zero-extend

Ports:
- CLOCK_50  in  1  single clock, all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- instr  in  16  instruction word [15:12] op, [11:8] rd, [7:4] ra/imm4, [3:0] rb
- exec_n  in  1  active-low execute key, asynchronous
- insp_n  in  1  active-low inspect key, asynchronous
- insp_a  in  4  inspect address A
- insp_b  in  4  inspect address B
- dbg_a  out  DATA_W  operand A register
- dbg_b  out  DATA_W  operand B register
- result  out  DATA_W  last ALU result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in WRITE
- illegal  out  1  last instruction had op 12..15
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag

## Operation
- Reset: every output is 0; all registers are 0; FSM goes to IDLE; synchronisers are set to 1; no write occurs.
- exec_n and insp_n each pass through a 2-flop synchroniser.
- start = synchronised exec_n falling edge, taken in IDLE only. Edges while busy are discarded, not queued.
- FSM:
  - IDLE: on start go to DECODE.
  - DECODE: latch op/rd/ra/rb/imm from instr. Go to READ, or to WRITE with illegal=1 if op >= 12.
  - READ: dbg_a <= R[ra], dbg_b <= R[rb]. Go to EXEC.
  - EXEC: result and flags are computed and registered. Go to WRITE.
  - WRITE: done=1; R[rd] <= result unless illegal, rd==0 or rd>=NREG. Go to IDLE.
- Inspect: in IDLE, while synchronised insp_n is low, dbg_a <= R[insp_a] and dbg_b <= R[insp_b] every cycle. Ignored while busy.
- r0 always reads 0.
- Ops, all results mod 2^DATA_W; imm = ext(instr[7:4]):
  - 0 ADD: ra+rb
  - 1 SUB: ra-rb
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLTU: ra<rb unsigned ? 1 : 0
  - 6 ADDI: rb+imm
  - 7 SUBI: rb-imm
  - 8 ANDI
  - 9 ORI
  - 10 SHLI: rb<<instr[7:4]; shift >= DATA_W gives 0
  - 11 LI: ext(instr[7:0])
- Flags:
  - flag_z = (result==0), updated by every legal op.
  - flag_c is updated by ops 0, 1, 6 and 7 only: carry-out for add, borrow (minuend < subtrahend unsigned) for sub.
- illegal is set in DECODE for op >= 12 and cleared in DECODE for a legal op. An illegal op leaves result, flags and registers unchanged.

## Timing
- Let k be the first rising edge sampling exec_n=0 in IDLE.
- DECODE is entered at k+2 (busy rises), READ at k+3, EXEC at k+4, WRITE at k+5. IDLE is entered at k+6, which is also the register write edge.
- done is high for exactly the one cycle between k+5 and k+6.
- Illegal path: DECODE at k+2, WRITE at k+3, IDLE at k+4; done still pulses.
- Minimum instruction-to-instruction spacing: exec_n high for at least 2 cycles, then low.
- Reset asserted in any state aborts immediately. The pending write is lost; outputs are 0 without waiting for a clock.
- Read-after-write: the next instruction reads the written value, guaranteed by FSM spacing with no bypass needed.

## Test plan
- Reset, then LI r1,0x05; LI r2,0x03; ADD r3,r1,r2 (0x0312) -> result=0x0008, z=0, c=0. Inspect r3 then shows dbg_a=0x0008.
- LI r1,0xFF; LI r2,0xFF; SHLI r2,8 giving 0xFF00; ORI… then ADD r4 of 0xFFFF+0x0001 (DATA_W=16) -> result=0x0000, z=1, c=1.
- SUB r5,r0,r1 with r1=5 -> result=0xFFFB, c=1. LI r0,0x7 then inspect r0 -> dbg_a=0; write to r0 is ignored.
- Op 0xC -> illegal=1, done pulses at k+3, result and flags unchanged. Next legal op clears illegal.
- exec_n strikes while busy -> exactly one instruction executes, with busy high from k+2 to k+6. Reset pulse at k+4 -> target register stays 0 and all outputs read 0.
- DATA_W=8, NREG=4, IMM_SIGNED=1: ADDI r1,rb=r0,imm=0xF -> result=0xFF. LI r5 -> register not written, and inspecting r5 reads 0.
